pong_ball_engine: RTL
=====================

Name: pong_ball_engine

Overview:
- Game-logic stage directly upstream of the pong renderer/top.
- Advances ball position once per game tick and bounces off top/bottom walls and both paddles.
- Detects missed balls, keeps both scores and runs the game state machine (idle / play / point pause / done).
- Outputs ball coordinates, scores and state consumed by the object renderer, LEDs and seven-segment display.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 10, ball width and height
- PADDLE_W, 10, paddle width
- PADDLE_H, 50, paddle height
- P1_X, 20, left paddle left edge
- P2_X, 620, right paddle left edge
- SPEED, 2, pixels moved per tick on each axis
- WIN_SCORE, 10, score that ends the game
- PAUSE_TICKS, 60, ticks held in point pause

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- tick  in  1  one-clk game-tick strobe
- start  in  1  level start button, already debounced
- paddle1_y  in  10  left paddle top Y, range 0..430
- paddle2_y  in  10  right paddle top Y, range 0..430
- ball_x  out  11  ball top-left X
- ball_y  out  10  ball top-left Y
- p1_score  out  4  left player score
- p2_score  out  4  right player score
- state  out  2  00 QI, 01 QGAME_1 (play), 10 QGAME_2 (point pause), 11 QDONE

Behaviour:
- Reset values: ball_x=315, ball_y=235, both scores 0, state QI, dx=right, dy=down, pause counter 0.
- All outputs are registered. Position updates land one clk after the tick.
- start is edge-detected internally with a registered previous value. start_rise = start & ~start_q.
- QI:
  - Ball held at centre.
  - start_rise -> QGAME_1.
  - tick is ignored.
- QGAME_1, on each tick:
  - Vertical: moving down and y+SPEED+BALL_SIZE >= SCREEN_H -> y=SCREEN_H-BALL_SIZE, dy=up.
  - Vertical: moving up and y < SPEED -> y=0, dy=down.
  - Otherwise y moves by ±SPEED.
  - Left-moving, left paddle:
    - Hit when x >= P1_X+PADDLE_W, x-SPEED <= P1_X+PADDLE_W, and the ball overlaps the paddle vertically.
    - Overlap means ball_y+BALL_SIZE > paddle1_y and ball_y < paddle1_y+PADDLE_H, using pre-move y.
    - On hit: x=P1_X+PADDLE_W, dx=right.
  - Left-moving, miss: x < SPEED -> p2_score+1, go to point handling.
  - Right-moving, right paddle: same rule against the face at P2_X-BALL_SIZE using paddle2_y. Miss when x+BALL_SIZE+SPEED > SCREEN_W -> p1_score+1.
  - Wall and paddle events in the same tick are both applied.
  - Arithmetic uses 12-bit signed intermediates so nothing wraps below 0.
- Point handling:
  - If the incremented score == WIN_SCORE -> QDONE.
  - Otherwise -> QGAME_2 with the pause counter cleared.
  - Ball freezes at its last position.
- QGAME_2:
  - Counts ticks.
  - At PAUSE_TICKS: recentre to (315,235), dx toward the player who conceded, dy=down, go to QGAME_1.
- QDONE:
  - Scores and ball hold.
  - start_rise -> clear scores, recentre, go to QI.
- start_rise outside QI/QDONE is ignored.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). Release is synchronous to clk.
- Scores saturate at WIN_SCORE; they never exceed 10.

Optional Feature:
- Macro PONG_SPEEDUP_EN.
- Defined:
  - Internal speed register, reset to SPEED.
  - Each paddle hit adds 1, capped at 2*SPEED.
  - Speed returns to SPEED on recentre.
  - All movement and boundary tests use the speed register.
- Undefined: speed is the constant SPEED; no extra register.

Decomposition:
- Shared package pong_pkg:
  - State encodings QI, QGAME_1, QGAME_2, QDONE (same values used by the LED decode).
  - Screen dimensions, paddle geometry constants and centre coordinates.
- One sub-module, pong_collide: combinational next-position and bounce/miss flags from (x, y, dx, dy, speed, paddle1_y, paddle2_y). The engine registers its outputs.

Test Plan:
- Reset low for 3 clk then high, ticks without start -> state=00, ball (315,235), scores 0.
- Start rise, 10 ticks -> state=01, ball_x=335, ball_y=255.
- Ball at y=469 moving down, tick -> y=470, dy up; next tick y=468.
- Ball x=32 moving left, paddle1_y=200, ball_y=220, tick -> x=30, dx right, no score change.
- Same with paddle1_y=0 until x<2 -> p2_score=1, state=10; after 60 ticks ball at (315,235) moving left, state=01.
- p1_score=9, right miss -> p1_score=10, state=11; start rise -> scores 0, state=00.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings, playfield geometry and score helper for the pong engine
package pong_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int BALL_SIZE   = 10;
    localparam int PADDLE_W    = 10;
    localparam int PADDLE_H    = 50;
    localparam int P1_X        = 20;
    localparam int P2_X        = 620;
    localparam int SPEED       = 2;
    localparam int WIN_SCORE   = 10;
    localparam int PAUSE_TICKS = 60;

    localparam logic [10:0] CENTRE_X = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) / 2);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'(WIN_SCORE)) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// rtl/pong_ball_engine_if.sv - controls in, ball/score/state out between game logic and its neighbours
interface pong_ball_engine_if;
    logic        tick;
    logic        start;
    logic [9:0]  paddle1_y;
    logic [9:0]  paddle2_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  p1_score;
    logic [3:0]  p2_score;
    logic [1:0]  state;

    modport master (
        output tick, start, paddle1_y, paddle2_y,
        input  ball_x, ball_y, p1_score, p2_score, state
    );

    modport slave (
        input  tick, start, paddle1_y, paddle2_y,
        output ball_x, ball_y, p1_score, p2_score, state
    );
endinterface

// File: rtl/pong_collide.sv
// rtl/pong_collide.sv - combinational next ball position with wall/paddle bounces and miss detection
module pong_collide
    import pong_pkg::*;
(
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        dx,
    input  logic        dy,
    input  logic [2:0]  speed,
    input  logic [9:0]  paddle1_y,
    input  logic [9:0]  paddle2_y,
    output logic [10:0] next_x,
    output logic [9:0]  next_y,
    output logic        next_dx,
    output logic        next_dy,
    output logic        miss_left,
    output logic        miss_right
);
    // dx=1 means moving right, dy=1 means moving down
    localparam logic signed [11:0] W      = 12'(SCREEN_W);
    localparam logic signed [11:0] H      = 12'(SCREEN_H);
    localparam logic signed [11:0] BALL   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH     = 12'(PADDLE_H);
    localparam logic signed [11:0] L_FACE = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] R_FACE = 12'(P2_X - BALL_SIZE);

    logic signed [11:0] sx, sy, sp, p1, p2, nx, ny;
    logic               overlap1, overlap2;

    always_comb begin
        sx         = $signed({1'b0, x});
        sy         = $signed({2'b00, y});
        sp         = $signed({9'd0, speed});
        p1         = $signed({2'b00, paddle1_y});
        p2         = $signed({2'b00, paddle2_y});
        nx         = sx;
        ny         = sy;
        next_dx    = dx;
        next_dy    = dy;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        overlap1   = (sy + BALL > p1) && (sy < p1 + PH);
        overlap2   = (sy + BALL > p2) && (sy < p2 + PH);

        if (dy) begin
            if (sy + sp + BALL >= H) begin
                ny      = H - BALL;
                next_dy = 1'b0;
            end else begin
                ny = sy + sp;
            end
        end else begin
            if (sy < sp) begin
                ny      = '0;
                next_dy = 1'b1;
            end else begin
                ny = sy - sp;
            end
        end

        if (!dx) begin
            if (sx >= L_FACE && sx - sp <= L_FACE && overlap1) begin
                nx      = L_FACE;
                next_dx = 1'b1;
            end else if (sx < sp) begin
                miss_left = 1'b1;
            end else begin
                nx = sx - sp;
            end
        end else begin
            if (sx <= R_FACE && sx + sp >= R_FACE && overlap2) begin
                nx      = R_FACE;
                next_dx = 1'b0;
            end else if (sx + BALL + sp > W) begin
                miss_right = 1'b1;
            end else begin
                nx = sx + sp;
            end
        end

        next_x = nx[10:0];
        next_y = ny[9:0];
    end
endmodule

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - ball motion, scoring and game FSM; PONG_SPEEDUP_EN enables per-hit ball speedup
module pong_ball_engine
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    pong_ball_engine_if.slave bus
);
    state_t      state_q, state_d;
    logic [10:0] x_q, x_d, next_x;
    logic [9:0]  y_q, y_d, next_y;
    logic        dx_q, dx_d, dy_q, dy_d, next_dx, next_dy;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [5:0]  pause_q, pause_d;
    logic        start_q, start_rise, miss_left, miss_right;
    logic [2:0]  speed;

`ifdef PONG_SPEEDUP_EN
    logic [2:0]  speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = 3'(SPEED);
`endif

    assign start_rise = bus.start & ~start_q;

    pong_collide u_collide (
        .x          (x_q),
        .y          (y_q),
        .dx         (dx_q),
        .dy         (dy_q),
        .speed      (speed),
        .paddle1_y  (bus.paddle1_y),
        .paddle2_y  (bus.paddle2_y),
        .next_x     (next_x),
        .next_y     (next_y),
        .next_dx    (next_dx),
        .next_dy    (next_dy),
        .miss_left  (miss_left),
        .miss_right (miss_right)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        pause_d = pause_q;
`ifdef PONG_SPEEDUP_EN
        speed_d = speed_q;
`endif
        case (state_q)
            QI: begin
                x_d = CENTRE_X;
                y_d = CENTRE_Y;
                if (start_rise) state_d = QGAME_1;
            end
            QGAME_1: if (bus.tick) begin
                // A miss freezes the ball; dx already points at the conceding side for the serve
                if (miss_left || miss_right) begin
                    if (miss_left) p2_d = sat_inc(p2_q);
                    else           p1_d = sat_inc(p1_q);
                    if ((miss_left ? p2_d : p1_d) == 4'(WIN_SCORE)) begin
                        state_d = QDONE;
                    end else begin
                        state_d = QGAME_2;
                        pause_d = '0;
                    end
                end else begin
                    x_d  = next_x;
                    y_d  = next_y;
                    dx_d = next_dx;
                    dy_d = next_dy;
`ifdef PONG_SPEEDUP_EN
                    if (next_dx != dx_q && speed_q < 3'(2 * SPEED)) speed_d = speed_q + 3'd1;
`endif
                end
            end
            QGAME_2: if (bus.tick) begin
                if (pause_q == 6'(PAUSE_TICKS - 1)) begin
                    x_d     = CENTRE_X;
                    y_d     = CENTRE_Y;
                    dy_d    = 1'b1;
                    pause_d = '0;
                    state_d = QGAME_1;
`ifdef PONG_SPEEDUP_EN
                    speed_d = 3'(SPEED);
`endif
                end else begin
                    pause_d = pause_q + 6'd1;
                end
            end
            QDONE: if (start_rise) begin
                p1_d    = '0;
                p2_d    = '0;
                x_d     = CENTRE_X;
                y_d     = CENTRE_Y;
                dx_d    = 1'b1;
                dy_d    = 1'b1;
                state_d = QI;
`ifdef PONG_SPEEDUP_EN
                speed_d = 3'(SPEED);
`endif
            end
            default: state_d = QI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= QI;
            x_q     <= CENTRE_X;
            y_q     <= CENTRE_Y;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            p1_q    <= '0;
            p2_q    <= '0;
            pause_q <= '0;
            start_q <= 1'b0;
`ifdef PONG_SPEEDUP_EN
            speed_q <= 3'(SPEED);
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            pause_q <= pause_d;
            start_q <= bus.start;
`ifdef PONG_SPEEDUP_EN
            speed_q <= speed_d;
`endif
        end
    end

    assign bus.ball_x   = x_q;
    assign bus.ball_y   = y_q;
    assign bus.p1_score = p1_q;
    assign bus.p2_score = p2_q;
    assign bus.state    = state_q;
endmodule
